// File: rtl/stage_sequencer.sv
// stage_sequencer: multi-cycle instruction stage sequencer.
// Steps each instruction through IF, IF_WAIT, ID, EX, MEM, MEM_WAIT and WB.
// In each state's exit cycle it pulses that stage's write enable.
// Optional feature macro STAGE_SEQ_MEM_HANDSHAKE_EN: IF_WAIT/MEM_WAIT exit on
// imem_ready/dmem_ready instead of on fixed wait counts.
// Ports:
//   clk, reset_n            clock, async active-low reset
//   run                     leave INIT when high
//   stall                   freeze the sequencer (overrides every exit condition)
//   ex_busy                 hold in EX while the EX unit is still computing
//   halt_req                in the WB exit cycle, go to HALT instead of IF
//   imem_ready, dmem_ready  memory ready strobes (handshake build only)
//   *_wren                  per-stage write enables, high only in exit cycles
//   stage_reset_n           pipeline-latch reset, low only in INIT
//   stage                   current state code
//   halted                  high in HALT
//   instret                 retired-instruction count (wraps)
module stage_sequencer #(
    parameter int unsigned IF_WAIT   = 1,
    parameter int unsigned MEM_WAIT  = 1,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned INSTRET_W = 32
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 run,
    input  logic                 stall,
    input  logic                 ex_busy,
    input  logic                 halt_req,
`ifdef STAGE_SEQ_MEM_HANDSHAKE_EN
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
`endif
    output logic                 pc_wren,
    output logic                 wb_if_wren,
    output logic                 if_id_wren,
    output logic                 id_ex_wren,
    output logic                 ex_mem_wren,
    output logic                 mem_wb_wren,
    output logic                 ram_wren,
    output logic                 reg_wren,
    output logic                 stage_reset_n,
    output logic [3:0]           stage,
    output logic                 halted,
    output logic [INSTRET_W-1:0] instret
);

    typedef enum logic [3:0] {
        S_INIT     = 4'd0,
        S_IF       = 4'd1,
        S_IF_WAIT  = 4'd2,
        S_ID       = 4'd3,
        S_EX       = 4'd4,
        S_MEM      = 4'd5,
        S_MEM_WAIT = 4'd6,
        S_WB       = 4'd7,
        S_HALT     = 4'd8
    } state_e;

    state_e               state_q, state_d;
    state_e               next_c;
    logic                 exit_c;
    logic                 illegal_c;
    logic                 if_done_c;
    logic                 mem_done_c;
    logic [INSTRET_W-1:0] instret_q, instret_d;

`ifdef STAGE_SEQ_MEM_HANDSHAKE_EN
    assign if_done_c  = imem_ready;
    assign mem_done_c = dmem_ready;
`else
    localparam logic [CNT_W-1:0] IF_LAST  = CNT_W'(IF_WAIT - 1);
    localparam logic [CNT_W-1:0] MEM_LAST = CNT_W'(MEM_WAIT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign if_done_c  = (cnt_q == IF_LAST);
    assign mem_done_c = (cnt_q == MEM_LAST);

    // Wait counter: zero outside the wait states so entry always starts at 0.
    always_comb begin
        cnt_d = '0;
        if ((state_q == S_IF_WAIT) || (state_q == S_MEM_WAIT)) begin
            if (stall)        cnt_d = cnt_q;
            else if (!exit_c) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    // Exit condition and successor for the current state.
    always_comb begin
        exit_c    = 1'b0;
        next_c    = S_INIT;
        illegal_c = 1'b0;
        case (state_q)
            S_INIT:     begin exit_c = run;        next_c = S_IF;       end
            S_IF:       begin exit_c = 1'b1;       next_c = S_IF_WAIT;  end
            S_IF_WAIT:  begin exit_c = if_done_c;  next_c = S_ID;       end
            S_ID:       begin exit_c = 1'b1;       next_c = S_EX;       end
            S_EX:       begin exit_c = !ex_busy;   next_c = S_MEM;      end
            S_MEM:      begin exit_c = 1'b1;       next_c = S_MEM_WAIT; end
            S_MEM_WAIT: begin exit_c = mem_done_c; next_c = S_WB;       end
            S_WB:       begin exit_c = 1'b1;       next_c = halt_req ? S_HALT : S_IF; end
            S_HALT:     begin exit_c = 1'b0;       next_c = S_HALT;     end
            default:    illegal_c = 1'b1;
        endcase
        if (stall) exit_c = 1'b0;
    end

    // Next state, Moore-decoded enables gated by the exit cycle, retire count.
    always_comb begin
        state_d     = state_q;
        instret_d   = instret_q;
        pc_wren     = 1'b0;
        wb_if_wren  = 1'b0;
        if_id_wren  = 1'b0;
        id_ex_wren  = 1'b0;
        ex_mem_wren = 1'b0;
        mem_wb_wren = 1'b0;
        ram_wren    = 1'b0;
        reg_wren    = 1'b0;
        if (illegal_c) begin
            state_d = S_INIT;
        end else if (exit_c) begin
            state_d = next_c;
            case (state_q)
                S_IF_WAIT:  if_id_wren  = 1'b1;
                S_ID:       id_ex_wren  = 1'b1;
                S_EX:       ex_mem_wren = 1'b1;
                S_MEM: begin
                    pc_wren  = 1'b1;
                    ram_wren = 1'b1;
                end
                S_MEM_WAIT: mem_wb_wren = 1'b1;
                S_WB: begin
                    wb_if_wren = 1'b1;
                    reg_wren   = 1'b1;
                    instret_d  = instret_q + INSTRET_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_INIT;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign stage         = state_q;
    assign halted        = (state_q == S_HALT);
    assign stage_reset_n = (state_q != S_INIT);
    assign instret       = instret_q;

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Parametrised multi-cycle stage sequencer for the core. It is the successor to the fixed 8-state stage controller. It steps each instruction through IF, IF_WAIT, ID, EX, MEM, MEM_WAIT and WB, and drives the per-stage write enables for PC, pipeline latches, RAM and register file. Over the fixed controller it adds:
- configurable memory wait lengths;
- external stall and multi-cycle EX hold;
- a halt state;
- a retired-instruction counter.

## Interface
Parameters:
- IF_WAIT, 1, instruction-memory wait cycles; legal range 1..2^CNT_W
- MEM_WAIT, 1, data-memory wait cycles; legal range 1..2^CNT_W
- CNT_W, 4, wait-counter width
- INSTRET_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset_n  in  1  asynchronous active-low reset
- run  in  1  leave INIT when high
- stall  in  1  freeze the sequencer
- ex_busy  in  1  multi-cycle EX unit still computing
- halt_req  in  1  sampled in the WB exit cycle
- pc_wren, wb_if_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, ram_wren, reg_wren  out  1 each  stage write enables
- stage_reset_n  out  1  pipeline-latch reset; low only in INIT
- stage  out  4  current state code
- halted  out  1  high in HALT
- instret  out  INSTRET_W  retired-instruction count

## Operation
- States and codes: INIT=0, IF=1, IF_WAIT=2, ID=3, EX=4, MEM=5, MEM_WAIT=6, WB=7, HALT=8. Codes 9..15 are illegal; the next state from any of them is INIT.
- Exit cycle: the cycle in which the state advances. No cycle is an exit cycle while stall=1. Otherwise the exit condition per state is:
  - INIT: run=1
  - IF_WAIT: wait counter = IF_WAIT-1
  - EX: ex_busy=0
  - MEM_WAIT: wait counter = MEM_WAIT-1
  - HALT: never
  - all other states: always
- Transitions:
  - INIT→IF→IF_WAIT→ID→EX→MEM→MEM_WAIT→WB
  - WB→HALT if halt_req=1, else WB→IF
  - HALT is left only by reset.
- Enables are Moore-decoded from state and asserted only in that state's exit cycle:
  - IF_WAIT: if_id_wren
  - ID: id_ex_wren
  - EX: ex_mem_wren
  - MEM: pc_wren and ram_wren, so ram_wren is always a single-cycle pulse
  - MEM_WAIT: mem_wb_wren
  - WB: wb_if_wren and reg_wren
- stage_reset_n = 0 in INIT, 1 in every other state.
- halted = 1 only in HALT; all enables are 0 in HALT.
- Wait counter:
  - cleared to 0 on entry to IF_WAIT or MEM_WAIT;
  - increments on each non-exit, non-stalled cycle in those states;
  - holds while stalled.
- instret:
  - increments by 1 in each WB exit cycle;
  - wraps from all-ones to 0;
  - frozen in HALT.
- Simultaneous events:
  - stall overrides ex_busy and the wait counter.
  - halt_req outside the WB exit cycle is ignored.

## Timing
- Asynchronous reset: state=INIT, counter=0, instret=0. Outputs during reset: all enables 0, stage_reset_n=0, stage=0, halted=0.
- Reset asserted mid-instruction: INIT takes effect immediately, without waiting for a clock. No partial enable pulse is produced after reset assertion.
- Release: with run=1 at release, IF is entered on the first rising edge after release.
- Cycles per instruction with no stall and no EX hold: 5 + IF_WAIT + MEM_WAIT. With the defaults this is 7, matching the fixed controller.
- Each cycle of ex_busy=1 in EX adds one cycle.
- Each cycle of stall adds one cycle in any state.

## Configuration
- STAGE_SEQ_MEM_HANDSHAKE_EN undefined: IF_WAIT and MEM_WAIT are fixed counts, as above.
- STAGE_SEQ_MEM_HANDSHAKE_EN defined:
  - adds input ports imem_ready and dmem_ready, 1 bit each;
  - the IF_WAIT exit condition becomes imem_ready=1 and the MEM_WAIT exit condition becomes dmem_ready=1;
  - the counter and the IF_WAIT/MEM_WAIT parameters are ignored;
  - stall still overrides;
  - a ready asserted in any other state has no effect.

## Test plan
- Defaults, run=1, 3 instructions, halt_req=1 in the third WB: 21 cycles from IF to HALT, instret=3, halted=1, one pulse of each enable per instruction, in stage order.
- IF_WAIT=3, MEM_WAIT=2: 10 cycles per instruction; if_id_wren is high only in the 3rd IF_WAIT cycle and mem_wb_wren only in the 2nd MEM_WAIT cycle.
- ex_busy held high for 4 cycles in EX with stall=1 overlapping 2 of them: EX lasts 5 cycles and ex_mem_wren pulses once, in the last one.
- stall=1 for 3 cycles in MEM: ram_wren and pc_wren stay 0 until the MEM exit cycle, then pulse for exactly 1 cycle; stage holds at 5.
- reset_n dropped asynchronously in MEM_WAIT: stage goes to 0, stage_reset_n to 0 and instret to 0 before the next edge; after release the sequence restarts at IF.
- INSTRET_W=4, 17 instructions: instret wraps 15→0 and reads 1 at the end; with the macro defined, imem_ready delayed 5 cycles stretches IF_WAIT to 6 cycles.
